// File: rtl/vc_read_scheduler_if.sv
// rtl/vc_read_scheduler_if.sv - buffer/allocator/crossbar signal bundle for one input-port read scheduler
interface vc_read_scheduler_if #(
    parameter int VC_NUM = 2
);
    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    logic [VC_NUM-1:0] is_empty_i;
    logic [VC_NUM-1:0] front_is_head_i;
    logic [VC_NUM-1:0] front_is_tail_i;
    logic [VC_NUM-1:0] va_grant_i;
    logic [VC_NUM-1:0] on_off_i;
    logic              switch_ready_i;

    logic [VC_NUM-1:0] read_o;
    logic              valid_o;
    logic [VC_W-1:0]   sel_vc_o;
    logic [VC_NUM-1:0] va_request_o;
    logic              error_o;

    // Environment side: buffers, VC allocator, crossbar.
    modport master (
        output is_empty_i, front_is_head_i, front_is_tail_i,
        output va_grant_i, on_off_i, switch_ready_i,
        input  read_o, valid_o, sel_vc_o, va_request_o, error_o
    );

    // Scheduler side.
    modport slave (
        input  is_empty_i, front_is_head_i, front_is_tail_i,
        input  va_grant_i, on_off_i, switch_ready_i,
        output read_o, valid_o, sel_vc_o, va_request_o, error_o
    );
endinterface

// File: rtl/vc_read_scheduler.sv
// rtl/vc_read_scheduler.sv - per-VC packet FSMs and round-robin read arbitration for one input port
module vc_read_scheduler #(
    parameter int VC_NUM = 2
) (
    input  logic                clk,
    input  logic                rst,
    vc_read_scheduler_if.slave  bus
);
    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VA     = 2'd1,
        ST_ACTIVE = 2'd2
    } vc_state_t;

    vc_state_t         state_q [VC_NUM];
    vc_state_t         state_d [VC_NUM];
    logic [VC_W-1:0]   rr_ptr_q;
    logic [VC_W-1:0]   rr_ptr_d;
    logic              error_q;
    logic              error_d;

    logic [VC_NUM-1:0] eligible;
    logic [VC_NUM-1:0] read_vec;
    logic [VC_NUM-1:0] va_req_vec;
    logic              grant_found;
    logic [VC_W-1:0]   grant_idx;
    logic [VC_W:0]     cand_sum;
    logic [VC_W-1:0]   cand_idx;

    // Register all per-VC states, the round-robin pointer and the sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= ST_IDLE;
            end
            rr_ptr_q <= '0;
            error_q  <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= state_d[v];
            end
            rr_ptr_q <= rr_ptr_d;
            error_q  <= error_d;
        end
    end

    // Pick the first eligible VC at or after rr_ptr (with wrap) and advance the pointer past it.
    always_comb begin
        eligible    = '0;
        read_vec    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        rr_ptr_d    = rr_ptr_q;
        for (int v = 0; v < VC_NUM; v++) begin
            eligible[v] = (state_q[v] == ST_ACTIVE) && !bus.is_empty_i[v] && bus.on_off_i[v];
        end
        for (int i = 0; i < VC_NUM; i++) begin
            // Explicit wrap keeps the search correct when VC_NUM is not a power of two.
            cand_sum = {1'b0, rr_ptr_q} + (VC_W+1)'(i);
            if (cand_sum >= (VC_W+1)'(VC_NUM)) begin
                cand_sum = cand_sum - (VC_W+1)'(VC_NUM);
            end
            cand_idx = cand_sum[VC_W-1:0];
            if (!grant_found && bus.switch_ready_i && eligible[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        if (grant_found) begin
            read_vec[grant_idx] = 1'b1;
            if (grant_idx == VC_W'(VC_NUM - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + VC_W'(1);
            end
        end
    end

    // Per-VC packet state transitions; a non-head flit at the front of an idle VC is a protocol error.
    always_comb begin
        error_d    = error_q;
        va_req_vec = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            state_d[v] = state_q[v];
            case (state_q[v])
                ST_IDLE: begin
                    if (!bus.is_empty_i[v]) begin
                        if (bus.front_is_head_i[v]) begin
                            state_d[v] = ST_VA;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                ST_VA: begin
                    va_req_vec[v] = 1'b1;
                    if (bus.va_grant_i[v]) begin
                        state_d[v] = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (read_vec[v] && bus.front_is_tail_i[v]) begin
                        state_d[v] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[v] = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.read_o       = read_vec;
    assign bus.valid_o      = grant_found;
    assign bus.sel_vc_o     = grant_found ? grant_idx : '0;
    assign bus.va_request_o = va_req_vec;
    assign bus.error_o      = error_q;
endmodule
